denise_clut_dump: RTL and testbench

- Readback side of the Denise colour table.
- Snoops the same colour-register write traffic that loads the CLUT: writes at 0x180-0x1BE, with AGA bank select and LOCT low-nibble writes.
- Keeps a 256-entry shadow copy of that traffic.
- On request, reads a range of entries back out and streams each as a packed 24-bit RGB word over a valid/ready port, for the OSD/scaler/host debug path.

---
 rtl/denise_clut_dump.sv | 129 ++++++++++++
 tb/tb_denise_clut_dump.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/denise_clut_dump.sv
// rtl/denise_clut_dump.sv - shadow copy of the Denise colour table with streaming readback
module denise_clut_dump #(
    parameter logic [8:0] COLORBASE = 9'h180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [11:0] data_in,
    input  logic [2:0]  bank,
    input  logic        loct,
    input  logic        dump_req,
    input  logic [7:0]  dump_first,
    input  logic [8:0]  dump_count,
    input  logic        dump_abort,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic [7:0]  out_index,
    output logic        out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  idx;
    logic [8:0]  rem;

    logic [11:0] hi_mem [0:255];
    logic [11:0] lo_mem [0:255];
    logic [11:0] q_hi;
    logic [11:0] q_lo;

    logic        snoop_we;
    logic [7:0]  snoop_addr;

    assign snoop_we   = clk7_en && (reg_address_in[8:6] == COLORBASE[8:6]);
    assign snoop_addr = {bank, reg_address_in[5:1]};

    // Shadow RAM follows the CLUT write traffic regardless of reset or dump state.
    always_ff @(posedge clk) begin
        if (snoop_we) begin
            lo_mem[snoop_addr] <= data_in;
            if (!loct) begin
                hi_mem[snoop_addr] <= data_in;
            end
        end
    end

    // Synchronous read; a same-edge snoop write lands after this read, so the beat sees old data.
    always_ff @(posedge clk) begin
        if (state == READ) begin
            q_hi <= hi_mem[idx];
            q_lo <= lo_mem[idx];
        end
    end

    function automatic logic [23:0] pack_rgb(input logic [11:0] hi, input logic [11:0] lo);
        return {hi[11:8], lo[11:8], hi[7:4], lo[7:4], hi[3:0], lo[3:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 24'd0;
            out_index <= 8'd0;
            idx       <= 8'd0;
            rem       <= 9'd0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && dump_abort) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (dump_req && dump_count != 9'd0) begin
                            idx   <= dump_first;
                            rem   <= (dump_count > 9'd256) ? 9'd256 : dump_count;
                            busy  <= 1'b1;
                            state <= READ;
                        end
                    end
                    READ: begin
                        state <= LATCH;
                    end
                    LATCH: begin
                        out_data  <= pack_rgb(q_hi, q_lo);
                        out_index <= idx;
                        out_last  <= (rem == 9'd1);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                    SEND: begin
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                            if (rem == 9'd1) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                rem   <= rem - 9'd1;
                                idx   <= idx + 8'd1;
                                state <= READ;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_denise_clut_dump.sv
// tb/tb_denise_clut_dump.sv - directed self-checking bench for denise_clut_dump
module tb_denise_clut_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic [8:1]  reg_address_in;
    logic [11:0] data_in;
    logic [2:0]  bank;
    logic        loct;
    logic        dump_req;
    logic [7:0]  dump_first;
    logic [8:0]  dump_count;
    logic        dump_abort;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [7:0]  out_index;
    logic        out_last;

    int compared   = 0;
    int mismatched = 0;

    logic [11:0] m_hi [0:255];
    logic [11:0] m_lo [0:255];
    int          got_beats;
    logic [23:0] got_first_data;
    logic [7:0]  got_first_index;

    denise_clut_dump #(.COLORBASE(9'h180)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .bank           (bank),
        .loct           (loct),
        .dump_req       (dump_req),
        .dump_first     (dump_first),
        .dump_count     (dump_count),
        .dump_abort     (dump_abort),
        .busy           (busy),
        .done           (done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_index      (out_index),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pack(input logic [7:0] e);
        return {m_hi[e][11:8], m_lo[e][11:8], m_hi[e][7:4], m_lo[e][7:4], m_hi[e][3:0], m_lo[e][3:0]};
    endfunction

    task automatic write_reg(input logic [8:0] a, input logic [11:0] d, input logic [2:0] b, input logic l);
        logic [7:0] e;
        reg_address_in = a[8:1];
        data_in        = d;
        bank           = b;
        loct           = l;
        clk7_en        = 1'b1;
        step;
        clk7_en        = 1'b0;
        e = {b, a[5:1]};
        m_lo[e] = d;
        if (!l) m_hi[e] = d;
    endtask

    task automatic run_dump(input string tag, input logic [7:0] first, input logic [8:0] count,
                            input int stall_beat, input int abort_beat);
        int exp_n;
        int beat;
        int stall;
        int dones;
        int cyc;
        logic [7:0] e;
        exp_n = (count > 9'd256) ? 256 : int'(count);
        beat = 0; stall = 0; dones = 0; cyc = 0;
        dump_first = first;
        dump_count = count;
        dump_req   = 1'b1;
        out_ready  = 1'b0;
        step;
        dump_req   = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        while (busy && cyc < 3000) begin
            cyc++;
            if (done) dones++;
            out_ready  = 1'b1;
            dump_abort = 1'b0;
            if (out_valid) begin
                e = first + 8'(beat);
                chk({tag, "_index"}, out_index, e);
                chk({tag, "_data"}, out_data, exp_pack(e));
                chk({tag, "_last"}, out_last, (beat == exp_n - 1));
                if (beat == 0) begin
                    got_first_data  = out_data;
                    got_first_index = out_index;
                end
                if (beat == stall_beat && stall < 10) begin
                    out_ready = 1'b0;
                    stall++;
                end
                if (beat == abort_beat) dump_abort = 1'b1;
                if (out_ready) beat++;
            end
            step;
        end
        dump_abort = 1'b0;
        out_ready  = 1'b0;
        chk({tag, "_timeout"}, (cyc < 3000), 1);
        chk({tag, "_done_at_end"}, done, 1);
        chk({tag, "_valid_at_end"}, out_valid, 0);
        if (done) dones++;
        step;
        if (done) dones++;
        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_beats"}, beat, (abort_beat >= 0) ? abort_beat + 1 : exp_n);
        if (stall_beat >= 0) chk({tag, "_stall_cycles"}, stall, 10);
        got_beats = beat;
    endtask

    initial begin
        reset = 1'b1; clk7_en = 1'b0; reg_address_in = 8'd0; data_in = 12'd0;
        bank = 3'd0; loct = 1'b0; dump_req = 1'b0; dump_first = 8'd0;
        dump_count = 9'd0; dump_abort = 1'b0; out_ready = 1'b0;
        step;
        step;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        reset = 1'b0;
        step;

        // Basic snoop and single-beat dump
        write_reg(9'h180, 12'hF80, 3'd0, 1'b0);
        run_dump("t1", 8'd0, 9'd1, -1, -1);
        chk("t1_hand_data", got_first_data, 24'hFF8800);
        chk("t1_hand_index", got_first_index, 0);

        // LOCT low-nibble write into bank 2
        write_reg(9'h182, 12'h123, 3'd2, 1'b0);
        write_reg(9'h182, 12'h456, 3'd2, 1'b1);
        run_dump("t2", 8'd65, 9'd1, -1, -1);
        chk("t2_hand_data", got_first_data, 24'h142536);
        chk("t2_hand_index", got_first_index, 65);

        for (int n = 0; n < 256; n++) begin
            write_reg(9'h180 + 9'(2 * (n % 32)), 12'(n), 3'(n / 32), 1'b0);
        end

        // Request-to-valid latency and read/write collision on entry 10
        dump_first = 8'd10; dump_count = 9'd1; dump_req = 1'b1;
        step;
        dump_req = 1'b0;
        chk("tim_k0_valid", out_valid, 0);
        reg_address_in = 8'hCA; data_in = 12'hABC; bank = 3'd0; loct = 1'b0; clk7_en = 1'b1;
        step;
        clk7_en = 1'b0;
        chk("tim_k1_valid", out_valid, 0);
        step;
        chk("tim_k2_valid", out_valid, 1);
        chk("coll_old_data", out_data, 24'h0000AA);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("coll_busy", busy, 0);
        chk("coll_done", done, 1);
        step;
        m_hi[10] = 12'hABC;
        m_lo[10] = 12'hABC;
        run_dump("coll_new", 8'd10, 9'd1, -1, -1);
        chk("coll_new_hand", got_first_data, 24'hAABBCC);

        // Zero count is ignored
        dump_first = 8'd3; dump_count = 9'd0; dump_req = 1'b1;
        step;
        dump_req = 1'b0;
        chk("zero_busy", busy, 0);
        chk("zero_done_a", done, 0);
        step;
        chk("zero_done_b", done, 0);
        chk("zero_busy_b", busy, 0);

        // Wrap, clamp and backpressure in one full-table dump
        run_dump("wrap", 8'd254, 9'd300, 3, -1);
        chk("wrap_hand_first_index", got_first_index, 254);
        chk("wrap_hand_first_data", got_first_data, 24'h00FFEE);

        // Abort at beat 5, then a fresh dump is accepted
        run_dump("abort", 8'd0, 9'd256, -1, 5);
        run_dump("post_abort", 8'd3, 9'd2, -1, -1);
        chk("post_abort_hand", got_first_data, 24'h000033);

        // Reset mid-dump: no done pulse
        dump_first = 8'd0; dump_count = 9'd50; dump_req = 1'b1;
        step;
        dump_req = 1'b0;
        out_ready = 1'b1;
        repeat (7) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        out_ready = 1'b0;
        chk("rmid_busy", busy, 0);
        chk("rmid_valid", out_valid, 0);
        chk("rmid_done", done, 0);
        chk("rmid_index", out_index, 0);
        chk("rmid_data", out_data, 0);
        step;
        chk("rmid_done_b", done, 0);
        chk("rmid_busy_b", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
